pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Central stall/flush/halt controller for the 5-stage Eriscv pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Merges stall requests from ID and EX with branch/jump redirects from EX.
//  Drives per-register stall and flush vectors plus the PC redirect.
//  Drains and holds the pipeline on an external halt handshake. Counts stall cycles for performance monitoring.
// PARAMETERS
//  DRAIN_CYCLES  4   cycles of bubble insertion before halt_ack (covers in-flight ID..WB)
//  CNT_W         32  stall-cycle counter width
// PORTS
//  clk            in   1      clock, rising edge
//  rst            in   1      reset, asynchronous, active-low (0 = reset)
//  stallreq_id_i  in   1      ID load-use hazard stall request
//  stallreq_ex_i  in   1      EX multi-cycle op not complete
//  jump_req_i     in   1      EX resolved taken branch/jump
//  jump_addr_i    in   32     redirect target from EX
//  halt_req_i     in   1      external halt request (level)
//  halt_ack_o     out  1      pipeline drained and frozen
//  stall_o        out  5      stall per reg: [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB
//  flush_o        out  2      bubble insert: [0]IF/ID [1]ID/EX
//  jump_o         out  1      PC loads jump_addr_o this cycle
//  jump_addr_o    out  32     PC redirect target
//  stall_cnt_o    out  CNT_W  saturating count of RUN-state cycles with stall_o[0]=1
// BEHAVIOUR
//  Reset: state=RUN, stall_o=0, flush_o=0, jump_o=0, jump_addr_o=0, halt_ack_o=0, stall_cnt_o=0, drain count=0.
//  stall_o/flush_o/jump_o: combinational from state + inputs (0-cycle latency). State, counters: registered.
//  RUN priority, highest first:
//   stallreq_ex_i=1 -> stall_o=5'b00111, flush_o=2'b10. A concurrent jump_req_i is ignored (EX re-presents it).
//   jump_req_i=1 -> jump_o=1, jump_addr_o=jump_addr_i, flush_o=2'b11, stall_o=0.
//   stallreq_id_i=1 -> stall_o=5'b00011, flush_o=2'b10.
//   otherwise all zero.
//  FSM states: RUN, DRAIN, HALTED.
//   RUN -> DRAIN when halt_req_i=1. Drain counter loads 0. Halt is entered even mid-stall.
//   DRAIN: stall_o[0]=1 (no fetch), flush_o[0]=1; EX/MEM/WB keep flowing.
//    stallreq_ex_i in DRAIN: stall_o=5'b00111, flush_o=2'b10, and the counter does not advance.
//    jump_req_i in DRAIN: jump_o=1 with stall_o[0]=0 that cycle, so the redirect target is kept for resume.
//    The counter advances on non-EX-stalled cycles. At count == DRAIN_CYCLES-1 -> HALTED.
//    halt_req_i=0 in DRAIN -> RUN next cycle, counter cleared, no ack.
//   HALTED: stall_o=5'b11111, flush_o=0, halt_ack_o=1 (registered, asserts on the first HALTED cycle).
//    Input requests are ignored.
//    halt_req_i=0 -> RUN next cycle, halt_ack_o=0 in that same cycle.
//  halt_ack_o is never 1 outside HALTED. halt_req_i pulses shorter than 1 cycle are not supported.
//  stall_cnt_o: +1 per cycle with state==RUN && stall_o[0]. Saturates at all-ones, with no wrap.
//  Async reset mid-DRAIN/HALTED: immediate return to reset values. The in-flight pipeline is reset by the same rst.
// STRUCTURE
//  Shared defines.v: state encodings (`CtrlRun/`CtrlDrain/`CtrlHalted), `StallBus 4:0, `FlushBus 1:0, stall bit indices.
//  Sub-module: sat_counter (param width, en, async active-low clr) for stall_cnt_o. FSM + priority mux inline.
//  Consumers: pc_reg honours stall_o[0]/jump_o. Pipeline regs hold on stall, load NOP on flush. Flush beats stall per reg.
// TESTING
//  1 Reset: rst=0 with random inputs -> all outputs 0, stall_cnt_o=0. Release -> RUN with zero outputs.
//  2 Load-use: stallreq_id_i=1 for 1 cycle -> stall_o=00011, flush_o=10; stall_cnt_o=1.
//  3 Priority: stallreq_ex_i=1, jump_req_i=1, addr=0x80 -> stall_o=00111, jump_o=0.
//    Next cycle ex=0, jump=1 -> jump_o=1, jump_addr_o=0x80, flush_o=11.
//  4 Halt: halt_req_i=1 in RUN -> 4 DRAIN cycles with stall_o[0]=1, then halt_ack_o=1, stall_o=11111.
//    Drop halt -> RUN and ack=0 next cycle.
//  5 Drain boundary: stallreq_ex_i=1 for 3 cycles during DRAIN -> ack after 4+3 cycles.
//    halt_req_i dropped at drain cycle 2 -> RUN, no ack.
//  6 Saturation: CNT_W=4, hold stallreq_id_i 20 cycles -> stall_cnt_o sticks at 15.
//    rst asserted mid-HALTED -> ack=0 immediately.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and encodings for the pipeline stall/flush/halt controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    CTRL_RUN    = 2'd0,
    CTRL_DRAIN  = 2'd1,
    CTRL_HALTED = 2'd2
  } ctrl_state_e;

  localparam int STALL_W  = 5;
  localparam int FLUSH_W  = 2;
  localparam int STALL_PC = 0;

  // Stall bus: [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB
  localparam logic [STALL_W-1:0] STALL_NONE    = 5'b00000;
  localparam logic [STALL_W-1:0] STALL_FETCH   = 5'b00001;
  localparam logic [STALL_W-1:0] STALL_LOADUSE = 5'b00011;
  localparam logic [STALL_W-1:0] STALL_EXBUSY  = 5'b00111;
  localparam logic [STALL_W-1:0] STALL_ALL     = 5'b11111;

  // Flush bus: [0]IF/ID [1]ID/EX
  localparam logic [FLUSH_W-1:0] FLUSH_NONE = 2'b00;
  localparam logic [FLUSH_W-1:0] FLUSH_IFID = 2'b01;
  localparam logic [FLUSH_W-1:0] FLUSH_IDEX = 2'b10;
  localparam logic [FLUSH_W-1:0] FLUSH_BOTH = 2'b11;

endpackage

// File: rtl/pipe_ctrl_sat.sv
// Saturating up-counter with asynchronous active-low clear; holds at all-ones.
module pipe_ctrl_sat #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             clr_n_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {WIDTH{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge clr_n_i) begin
    if (!clr_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush/redirect controller for the 5-stage pipeline with drain-and-halt
// handshake and a saturating stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_id_i,
  input  logic               stallreq_ex_i,
  input  logic               jump_req_i,
  input  logic [31:0]        jump_addr_i,
  input  logic               halt_req_i,
  output logic               halt_ack_o,
  output logic [STALL_W-1:0] stall_o,
  output logic [FLUSH_W-1:0] flush_o,
  output logic               jump_o,
  output logic [31:0]        jump_addr_o,
  output logic [CNT_W-1:0]   stall_cnt_o
);

  localparam int DC_W = $clog2(DRAIN_CYCLES) + 1;
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DRAIN_CYCLES - 1);

  ctrl_state_e     state_q, state_d;
  logic [DC_W-1:0] dc_q, dc_d;
  logic            ack_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CTRL_RUN;
      dc_q    <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dc_q    <= dc_d;
      ack_q   <= (state_d == CTRL_HALTED);
    end
  end

  // The drain counter only advances on cycles where EX actually moves forward.
  always_comb begin
    state_d = state_q;
    dc_d    = dc_q;
    unique case (state_q)
      CTRL_RUN: begin
        if (halt_req_i) begin
          state_d = CTRL_DRAIN;
          dc_d    = '0;
        end
      end
      CTRL_DRAIN: begin
        if (!halt_req_i) begin
          state_d = CTRL_RUN;
          dc_d    = '0;
        end else if (!stallreq_ex_i) begin
          if (dc_q == DC_LAST) begin
            state_d = CTRL_HALTED;
            dc_d    = '0;
          end else begin
            dc_d = dc_q + 1'b1;
          end
        end
      end
      CTRL_HALTED: begin
        if (!halt_req_i) state_d = CTRL_RUN;
      end
      default: begin
        state_d = CTRL_RUN;
        dc_d    = '0;
      end
    endcase
  end

  // Outputs are forced quiet while reset is held, whatever the inputs do.
  always_comb begin
    stall_o     = STALL_NONE;
    flush_o     = FLUSH_NONE;
    jump_o      = 1'b0;
    jump_addr_o = '0;
    if (rst) begin
      unique case (state_q)
        CTRL_RUN, CTRL_DRAIN: begin
          if (stallreq_ex_i) begin
            stall_o = STALL_EXBUSY;
            flush_o = FLUSH_IDEX;
          end else if (jump_req_i) begin
            jump_o      = 1'b1;
            jump_addr_o = jump_addr_i;
            flush_o     = FLUSH_BOTH;
          end else if (stallreq_id_i) begin
            stall_o = STALL_LOADUSE;
            flush_o = FLUSH_IDEX;
          end else if (state_q == CTRL_DRAIN) begin
            stall_o = STALL_FETCH;
            flush_o = FLUSH_IFID;
          end
        end
        CTRL_HALTED: stall_o = STALL_ALL;
        default: ;
      endcase
    end
  end

  assign halt_ack_o = ack_q;

  pipe_ctrl_sat #(
    .WIDTH(CNT_W)
  ) u_stall_cnt (
    .clk_i  (clk),
    .clr_n_i(rst),
    .en_i   ((state_q == CTRL_RUN) && stall_o[STALL_PC]),
    .cnt_o  (stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a 32-bit-counter and a 4-bit-counter instance share stimulus.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_id_i = 1'b0, stallreq_ex_i = 1'b0, jump_req_i = 1'b0, halt_req_i = 1'b0;
  logic [31:0] jump_addr_i = '0;

  logic        halt_ack_o, jump_o, ack4, jump4;
  logic [4:0]  stall_o, stall4;
  logic [1:0]  flush_o, flush4;
  logic [31:0] jump_addr_o, addr4, stall_cnt_o;
  logic [3:0]  cnt4;

  pipe_ctrl #(.DRAIN_CYCLES(4), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .stallreq_id_i(stallreq_id_i), .stallreq_ex_i(stallreq_ex_i),
    .jump_req_i(jump_req_i), .jump_addr_i(jump_addr_i), .halt_req_i(halt_req_i),
    .halt_ack_o(halt_ack_o), .stall_o(stall_o), .flush_o(flush_o), .jump_o(jump_o),
    .jump_addr_o(jump_addr_o), .stall_cnt_o(stall_cnt_o)
  );

  pipe_ctrl #(.DRAIN_CYCLES(4), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .stallreq_id_i(stallreq_id_i), .stallreq_ex_i(stallreq_ex_i),
    .jump_req_i(jump_req_i), .jump_addr_i(jump_addr_i), .halt_req_i(halt_req_i),
    .halt_ack_o(ack4), .stall_o(stall4), .flush_o(flush4), .jump_o(jump4),
    .jump_addr_o(addr4), .stall_cnt_o(cnt4)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  stall;
    logic [1:0]  flush;
    logic        jump;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model state: 0 RUN, 1 DRAIN, 2 HALTED
  int          m_st, m_dc;
  logic        m_ack;
  logic [31:0] m_cnt;
  logic [3:0]  m_cnt4;
  logic        obs_ack;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_dc = 0; m_ack = 1'b0; m_cnt = '0; m_cnt4 = '0;
  endtask

  task automatic step(input logic ex, input logic id, input logic jmp,
                      input logic [31:0] a, input logic halt);
    exp_t e, q;
    stallreq_ex_i = ex; stallreq_id_i = id; jump_req_i = jmp;
    jump_addr_i = a;    halt_req_i = halt;
    e = '0;
    e.ack = m_ack; e.cnt = m_cnt; e.cnt4 = m_cnt4;
    if (m_st == 2)      e.stall = 5'b11111;
    else if (ex)        begin e.stall = 5'b00111; e.flush = 2'b10; end
    else if (jmp)       begin e.jump = 1'b1; e.addr = a; e.flush = 2'b11; end
    else if (id)        begin e.stall = 5'b00011; e.flush = 2'b10; end
    else if (m_st == 1) begin e.stall = 5'b00001; e.flush = 2'b01; end
    sb.push_back(e);

    @(negedge clk);
    q = sb.pop_front();
    chk("stall", stall_o, q.stall);
    chk("flush", flush_o, q.flush);
    chk("jump", {jump_o, jump_addr_o}, {q.jump, q.addr});
    chk("ack", halt_ack_o, q.ack);
    chk("cnt", stall_cnt_o, q.cnt);
    chk("cnt4", cnt4, q.cnt4);
    chk("dut4_ctl", {stall4, flush4, jump4, addr4, ack4}, {q.stall, q.flush, q.jump, q.addr, q.ack});
    obs_ack = halt_ack_o;

    if (m_st == 0 && e.stall[0]) begin
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 1;
    end
    case (m_st)
      0: if (halt) begin m_st = 1; m_dc = 0; end
      1: begin
        if (!halt) begin m_st = 0; m_dc = 0; end
        else if (!ex) begin
          if (m_dc == 3) begin m_st = 2; m_dc = 0; end
          else m_dc++;
        end
      end
      default: if (!halt) m_st = 0;
    endcase
    m_ack = (m_st == 2);
    @(posedge clk); #1;
  endtask

  initial begin
    int   first;
    logic seen;

    // Reset held with random inputs
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      stallreq_id_i = 1'($urandom); stallreq_ex_i = 1'($urandom);
      jump_req_i = 1'($urandom); jump_addr_i = $urandom; halt_req_i = 1'($urandom);
      #2;
      chk("rst_outs", {stall_o, flush_o, jump_o, jump_addr_o, halt_ack_o}, '0);
      chk("rst_cnt", {stall_cnt_o, cnt4}, '0);
    end
    stallreq_id_i = 0; stallreq_ex_i = 0; jump_req_i = 0; jump_addr_i = '0; halt_req_i = 0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    step(0, 0, 0, 32'h0, 0);

    // Load-use stall
    step(0, 1, 0, 32'h0, 0);
    chk("cnt_after_loaduse", stall_cnt_o, 1);
    step(0, 0, 0, 32'h0, 0);

    // EX stall beats jump, then jump re-presented
    step(1, 0, 1, 32'h80, 0);
    step(0, 0, 1, 32'h80, 0);
    step(0, 0, 0, 32'h0, 0);

    // Halt: one RUN cycle plus four DRAIN cycles before ack
    first = -1;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 32'h0, 1);
      if (obs_ack && first < 0) begin first = i; break; end
    end
    chk("halt_latency", first, 5);
    step(1, 1, 1, 32'h44, 1);
    step(0, 0, 0, 32'h0, 0);
    step(0, 0, 0, 32'h0, 0);
    chk("ack_after_release", obs_ack, 0);

    // EX stall for 3 cycles mid-drain extends the drain to 7 cycles
    first = -1;
    for (int i = 0; i < 20; i++) begin
      step((i >= 2 && i < 5), 0, 0, 32'h0, 1);
      if (obs_ack && first < 0) begin first = i; break; end
    end
    chk("drain_ex_latency", first, 8);
    step(0, 0, 0, 32'h0, 0);
    step(0, 0, 0, 32'h0, 0);

    // Halt abandoned at drain cycle 2, with a redirect during the drain
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 1, 32'h1234, 1);
    step(0, 0, 0, 32'h0, 0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 32'h0, 0);
      seen |= obs_ack;
    end
    chk("no_ack_after_abort", seen, 0);

    // Saturation of the 4-bit counter
    for (int i = 0; i < 20; i++) step(0, 1, 0, 32'h0, 0);
    chk("cnt4_sat", cnt4, 4'hF);
    step(0, 0, 0, 32'h0, 0);

    // Async reset in HALTED
    first = -1;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 32'h0, 1);
      if (obs_ack && first < 0) begin first = i; break; end
    end
    chk("halt_again", first, 5);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_halt_ack", {halt_ack_o, ack4}, 2'b00);
    chk("rst_mid_halt_outs", {stall_o, flush_o, jump_o}, '0);
    chk("rst_mid_halt_cnt", {stall_cnt_o, cnt4}, '0);
    halt_req_i = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    sb.delete();
    step(0, 0, 0, 32'h0, 0);
    step(0, 1, 0, 32'h0, 0);
    step(0, 0, 0, 32'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
